// File: rtl/icache_boot_loader.sv
// Boot-time icache writer: packs a host byte stream into 32-bit words and writes them from address 0.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte (CHK/ERR states, sticky boot_err).
module icache_boot_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              host_valid,
  input  logic [7:0]        host_data,
  output logic              host_ready,
  output logic [ADDR_W-1:0] boot_addr,
  output logic [DATA_W-1:0] boot_datai,
  output logic              boot_web,
  output logic              boot_up,
  output logic              boot_done,
  output logic              boot_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    RUN   = 3'd4
`ifdef BOOT_CHECKSUM_EN
    ,
    CHK   = 3'd5,
    ERR   = 3'd6
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic                done_q, done_d;
  logic                accept;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  // Handshake outputs decode straight from the state register, so host inputs never reach host_ready.
  always_comb begin
    host_ready = 1'b0;
    unique case (state_q)
      LEN, DATA: host_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      CHK:       host_ready = 1'b1;
`endif
      default:   host_ready = 1'b0;
    endcase
  end

  assign accept     = host_valid && host_ready;
  assign boot_addr  = addr_q;
  assign boot_datai = data_q;
  assign boot_web   = (state_q != WRITE);
  assign boot_up    = (state_q != RUN);
  assign boot_done  = done_q;
`ifdef BOOT_CHECKSUM_EN
  assign boot_err   = (state_q == ERR);
`else
  assign boot_err   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    byte_idx_d = byte_idx_q;
    done_d     = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        if (accept) begin
          len_d      = host_data;
          cnt_d      = '0;
          addr_d     = '0;
          byte_idx_d = '0;
`ifdef BOOT_CHECKSUM_EN
          csum_d     = '0;
`endif
          state_d    = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          data_d[8*byte_idx_q +: 8] = host_data;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_d     = csum_q ^ host_data;
`endif
          if (byte_idx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        // Address wraps naturally when the load is larger than the icache.
        addr_d = addr_q + ADDR_W'(1);
        if (cnt_q == len_q) begin
`ifdef BOOT_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = RUN;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = DATA;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          if (host_data == csum_q) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
          end
        end
      end
      ERR: begin
        if (start) state_d = LEN;
      end
`endif
      RUN: begin
        if (start) state_d = LEN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      byte_idx_q <= '0;
      done_q     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      byte_idx_q <= byte_idx_d;
      done_q     <= done_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule
